// File: rtl/debug_pkg.sv
// debug_pkg: shared definitions for the debug-word UART transmitter.
//   ASCII_CR / ASCII_LF : line terminator characters appended to every word
//   NUM_HEX             : hex characters per 32-bit word
//   tx_state_t          : per-character serialiser states
//   frame_state_t       : word-level sequencer states
//   hex2ascii()         : nibble -> uppercase ASCII hex digit
package debug_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int unsigned NUM_HEX = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  typedef enum logic {
    FR_IDLE,
    FR_SEND
  } frame_state_t;

  // 0-9 -> '0'..'9' (0x30..0x39), A-F -> 'A'..'F' (0x41..0x46)
  function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   valid    : byte offered for transmission
//   tx_byte  : byte to send (LSB first)
//   ready    : byte is taken when valid && ready; high while idle and in the
//              final cycle of a stop bit so characters chain with no gap
//   tx       : UART line, idle high
module uart_tx_byte
  import debug_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] tx_byte,
  output logic       ready,
  output logic       tx
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_t   r_state;
  tx_state_t   w_state_nxt;
  logic [15:0] r_baud;
  logic [15:0] w_baud_nxt;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic        w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    ready       = 1'b0;
    tx          = 1'b1;
    case (r_state)
      IDLE: begin
        ready      = 1'b1;
        w_baud_nxt = '0;
        if (valid) begin
          w_state_nxt = START;
          w_shift_nxt = tx_byte;
          w_bit_nxt   = '0;
        end
      end
      START: begin
        tx = 1'b0;
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      DATA: begin
        tx = r_shift[r_bit];
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      STOP: begin
        // Last stop cycle doubles as the hand-off point for the next byte,
        // so the next start bit follows immediately.
        ready = w_bit_end;
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (valid) begin
            w_state_nxt = START;
            w_shift_nxt = tx_byte;
            w_bit_nxt   = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/debug_uart_tx.sv
// debug_uart_tx: sends a snapshot of the 32-bit core debug word as eight
// uppercase ASCII hex characters followed by CR LF, 8N1.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : transmit request, accepted when not busy
//   data  : debug word, captured on acceptance
//   busy  : high from the cycle after acceptance until the frame completes
//   done  : one-cycle pulse in the cycle after the final stop bit
//   tx    : UART line, idle high
module debug_uart_tx
  import debug_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned NUM_HEX      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam logic [3:0] CHAR_LAST = 4'(NUM_HEX + 1);
  localparam logic [3:0] CHAR_CR   = 4'(NUM_HEX);

  frame_state_t r_state;
  frame_state_t w_state_nxt;
  logic [3:0]   r_char_idx;
  logic [31:0]  r_shadow;
  logic         r_done;

  logic         w_accept;
  logic         w_frame_end;
  logic         w_next_char;
  logic         w_valid;
  logic         w_ready;
  logic [7:0]   w_byte;
  logic [31:0]  w_src;
  logic [3:0]   w_idx;
  logic [31:0]  w_shifted;

  assign w_accept    = start && (r_state == FR_IDLE);
  assign w_frame_end = (r_state == FR_SEND) && w_ready && (r_char_idx == CHAR_LAST);
  assign w_next_char = (r_state == FR_SEND) && w_ready && (r_char_idx != CHAR_LAST);
  assign w_valid     = w_accept || w_next_char;

  // The first character is taken straight from the input word in the
  // acceptance cycle so its start bit lines up with busy rising; later
  // characters come from the shadow copy.
  assign w_src     = w_accept ? data : r_shadow;
  assign w_idx     = w_accept ? 4'd0 : (r_char_idx + 4'd1);
  assign w_shifted = w_src << {w_idx[2:0], 2'b00};

  always_comb begin
    w_byte = ASCII_LF;
    if (w_idx < CHAR_CR) begin
      w_byte = hex2ascii(w_shifted[31:28]);
    end else if (w_idx == CHAR_CR) begin
      w_byte = ASCII_CR;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FR_IDLE: if (w_accept)    w_state_nxt = FR_SEND;
      FR_SEND: if (w_frame_end) w_state_nxt = FR_IDLE;
      default:                  w_state_nxt = FR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FR_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_char_idx <= '0;
      r_shadow   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_frame_end;
      if (w_accept) begin
        r_shadow   <= data;
        r_char_idx <= '0;
      end else if (w_next_char) begin
        r_char_idx <= r_char_idx + 4'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (w_valid),
    .tx_byte (w_byte),
    .ready   (w_ready),
    .tx      (tx)
  );

  assign busy = (r_state == FR_SEND);
  assign done = r_done;

endmodule

// File: tb/tb_debug_uart_tx.sv
module tb_debug_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] data = '0;
  logic        busy;
  logic        done;
  logic        tx;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  int mis_cnt = 0;
  int lo_cnt  = 0;

  debug_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .NUM_HEX     (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .data  (data),
    .busy  (busy),
    .done  (done),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Bit-timing checker: any tx edge while busy must fall on a bit boundary
  // measured from the cycle busy rose.
  int   rel = 0;
  logic prev_tx = 1'b1;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (busy && !prev_busy) rel = 0;
    else rel++;
    if (busy && prev_busy && (tx !== prev_tx) && ((rel % CPB) != 0)) mis_cnt++;
    prev_tx   = tx;
    prev_busy = busy;
  end

  // UART monitor: decodes characters and scores them against the queue.
  initial begin
    logic [7:0] rx;
    logic [7:0] e;
    logic       stop_ok;
    logic       ok;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        ok = 1'b1;
        rx = '0;
        stop_ok = 1'b0;
        for (int k = 1; k < 10 * CPB; k++) begin
          @(negedge clk);
          if (!rst_n) begin
            ok = 1'b0;
            break;
          end
          if ((k % CPB) == CPB / 2 && k >= CPB + CPB / 2 && k < 9 * CPB) rx[(k - CPB) / CPB] = tx;
          if (k == 9 * CPB + CPB / 2) stop_ok = tx;
        end
        if (ok) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_char: got %0h expected none", rx);
          end else begin
            e = exp_q.pop_front();
            chk("char", {24'h0, rx}, {24'h0, e});
            chk("stop_bit", {31'h0, stop_ok}, 32'h1);
          end
        end
      end
    end
  end

  // One frame: pulse start, optionally poke start/data mid-frame, wait for done.
  task automatic run_frame(input logic [31:0] w, input string s, input int poke_at);
    int c;
    int busy_cnt;
    int done_cnt;
    int extra;
    bit got_done;
    push_str(s);
    start = 1'b1;
    data  = w;
    @(negedge clk);
    start    = 1'b0;
    c        = 1;
    busy_cnt = 0;
    done_cnt = 0;
    got_done = 0;
    lo_cnt   = 0;
    chk("busy_rise", {31'h0, busy}, 32'h1);
    chk("first_start_bit", {31'h0, tx}, 32'h0);
    while (!got_done && c < 1000) begin
      if (busy) busy_cnt++;
      if (c <= 2 * CPB && tx === 1'b0) lo_cnt++;
      if (c == poke_at) begin
        start = 1'b1;
        data  = 32'hDEADBEEF;
      end else if (c == poke_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        done_cnt++;
        got_done = 1;
        chk("busy_low_at_done", {31'h0, busy}, 32'h0);
      end
      @(negedge clk);
      c++;
    end
    if (!got_done) chk("done_timeout", 32'h0, 32'h1);
    chk("busy_cycles", busy_cnt, 10 * 10 * CPB);
    extra = 0;
    for (int i = 0; i < 3 * 10 * CPB; i++) begin
      if (busy) extra++;
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("no_second_frame", extra, 0);
    chk("done_pulses", done_cnt, 1);
  endtask

  initial begin
    int c;
    int busy_cnt;
    int done_cnt;
    int rise1;
    int rise2;
    int tx_lo;
    logic pb;

    // Reset state
    #2;
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic frame; '1' = 0x31 has LSB 1, so exactly CPB low cycles in the
    // first two bit periods means a start bit of exactly CPB cycles.
    run_frame(32'h1234ABCD, "1234ABCD", 0);
    chk("start_bit_len", lo_cnt, CPB);

    // Hex boundaries
    run_frame(32'h09AF0000, "09AF0000", 0);
    run_frame(32'hFFFFFFFF, "FFFFFFFF", 0);

    // Start while busy with changed data: ignored, original word sent
    run_frame(32'h55667788, "55667788", 50);
    data = '0;

    // Back-to-back with start held
    push_str("00000001");
    push_str("00000001");
    start = 1'b1;
    data  = 32'h00000001;
    @(negedge clk);
    c = 1; busy_cnt = 0; done_cnt = 0; rise1 = 1; rise2 = -1; pb = 1'b1;
    while (done_cnt < 2 && c < 2000) begin
      if (busy) busy_cnt++;
      if (busy && !pb) begin
        rise2 = c;
        start = 1'b0;
        chk("b2b_start_bit", {31'h0, tx}, 32'h0);
      end
      if (done) done_cnt++;
      pb = busy;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk("b2b_done_count", done_cnt, 2);
    chk("b2b_busy_cycles", busy_cnt, 2 * 10 * 10 * CPB);
    chk("b2b_rise_gap", rise2 - rise1, 10 * 10 * CPB + 1);
    repeat (3 * 10 * CPB) begin
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    chk("b2b_no_third", busy_cnt, 2 * 10 * 10 * CPB);

    // Reset mid-frame at cycle 123
    push_str("12345678");
    start = 1'b1;
    data  = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    repeat (122) @(negedge clk);
    chk("pre_reset_busy", {31'h0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", {31'h0, tx}, 32'h1);
    chk("async_rst_busy", {31'h0, busy}, 32'h0);
    chk("async_rst_done", {31'h0, done}, 32'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tx_lo = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) tx_lo++;
    end
    chk("idle_after_reset", tx_lo, 0);
    run_frame(32'hCAFE0042, "CAFE0042", 0);

    chk("bit_alignment", mis_cnt, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/debug_uart_tx.md
Name: debug_uart_tx

Overview:
- Serialises the 32-bit data-memory debug word (`out_debug`, selected by `in_debug`) from the single-cycle MIPS core as 8 uppercase ASCII hex characters plus CR LF over a UART TX line.
- Sits directly downstream of the core's debug port. On board it gives a host terminal visibility into data memory.
- On `start`, it latches a snapshot of the word, frames it as 8N1 characters, and reports completion.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
- NUM_HEX, 8, hex characters per word (fixed 32-bit word / 4).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to transmit `data`; sampled on rising `clk`.
- data  input  32  debug word (core `out_debug`); sampled only when a start is accepted.
- busy  output  1  high from the cycle after start acceptance until frame completion.
- done  output  1  one-cycle pulse when the final stop bit ends.
- tx  output  1  UART line, idle high.

Behaviour:
- Reset (async, rst_n=0): tx=1, busy=0, done=0, FSM=IDLE, all counters=0, shadow register=0. Reset mid-frame aborts immediately: tx returns high asynchronously and no partial character completes.
- Start acceptance: start=1 && busy=0 on a rising edge latches data into the 32-bit shadow register. busy=1 from the next cycle. start while busy=1 is ignored (no queueing).
- Frame content: 10 characters in this order:
  - nibbles [31:28] down to [3:0], mapped 0-9 -> 0x30-0x39 and A-F -> 0x41-0x46;
  - then 0x0D, then 0x0A.
- Character format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles. There is no idle gap between characters.
- Latency:
  - The first start bit drives tx on the cycle busy rises (1 cycle after acceptance).
  - A full frame is 10 chars x 10 bits x CLKS_PER_BIT cycles.
- FSM states and transitions:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START (next char) while char_idx<9.
  - STOP -> IDLE when char_idx==9.
- Completion: in the cycle the FSM enters IDLE, done=1 and busy=0 together. done is high for exactly 1 cycle.
- Back-to-back operation: start asserted in the same cycle done=1 is accepted (busy=0 that cycle), so the next frame begins with no extra idle bit time.
- Counters:
  - Baud counter is 16 bits, wraps 0..CLKS_PER_BIT-1.
  - Bit index is 3 bits; character index is 4 bits, 0..9.
- Snapshot rule: changes on `data` while busy have no effect on the current frame.

Decomposition:
- Shared package `debug_pkg`:
  - ASCII_CR=8'h0D, ASCII_LF=8'h0A;
  - function `hex2ascii(nibble)`;
  - FSM state typedef/localparams IDLE, START, DATA, STOP.
- Sub-module `uart_tx_byte`, the 8N1 byte serialiser:
  - ports clk, rst_n, valid, byte[7:0], ready, tx;
  - parameter CLKS_PER_BIT.
- The top-level `debug_uart_tx` sequences characters into it. When split this way, the parent keeps the character index and shadow register, and the child owns the baud counter, bit index and START/DATA/STOP states. The frame timing above (no inter-character gap, done on the cycle the last stop bit ends) must be preserved.

Test Plan (CLKS_PER_BIT=4):
- Basic frame: data=32'h1234ABCD, 1-cycle start. Required response:
  - the UART monitor decodes "1234ABCD\r\n";
  - busy high for exactly 400 cycles;
  - done pulses once, on the cycle busy falls.
- Hex boundaries: data=32'h09AF0000 decodes to chars 0x30,0x39,0x41,0x46,0x30,0x30,0x30,0x30,0x0D,0x0A. data=32'hFFFFFFFF decodes to "FFFFFFFF\r\n".
- Start while busy, plus data change: assert start 50 cycles into a frame with data=32'hDEADBEEF.
  - The current frame still outputs the original word.
  - No second frame follows.
  - done pulses exactly once.
- Back-to-back: hold start high continuously with data=32'h00000001. Required response:
  - two consecutive frames "00000001\r\n";
  - stop bit of LF directly followed by the next start bit;
  - total 800 cycles.
- Reset mid-frame: drop rst_n at cycle 123 of a frame. Required response:
  - tx=1, busy=0, done=0 immediately (async);
  - after release, tx stays idle high until a new start;
  - a new frame with 32'hCAFE0042 decodes correctly.
- Bit timing check: every tx transition is aligned to a multiple of 4 cycles from the cycle busy rises. The start bit measures exactly 4 cycles low.
